// File: rtl/gpio_ctrl_if.sv
// Register bus between a host and gpio_ctrl: addressed single-cycle
// write/read strobes, with registered read data qualified by rvalid.
interface gpio_ctrl_if;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    output addr, wdata, we, re,
    input  rdata, rvalid
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, rvalid
  );
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: register-mapped GPIO block with a 2-flop input synchronizer,
// per-pin output/enable registers and a programmable clock divider (xclk).
// Optional feature macro GPIO_EDGE_IRQ_EN adds per-pin edge detection,
// a rw1c STATUS register, MASK/RISE_EN/FALL_EN and a level irq. Without
// it, addresses 3-6 read as zero, writes to them are dropped and irq is 0.
module gpio_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             xclk,
  output logic             done,
  output logic             irq
);

  localparam logic [2:0] A_OUT    = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_MASK   = 3'd4;
  localparam logic [2:0] A_RISE   = 3'd5;
  localparam logic [2:0] A_FALL   = 3'd6;
  localparam logic [2:0] A_DIV    = 3'd7;

  // Roughly mid-scale divide so an unconfigured xclk blinks slowly.
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'((64'd1 << (DIV_W - 1)) - 64'd1);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] cnt;
  logic [WIDTH-1:0] wdata_w;
  logic [31:0]      rd_mux;
  logic [31:0]      rdata_r;
  logic             rvalid_r;
  logic             xclk_r;
  logic             done_r;
  logic             wr_div;
  logic             unused_wdata;

  assign wdata_w      = bus.wdata[WIDTH-1:0];
  assign wr_div       = bus.we && (bus.addr == A_DIV);
  assign unused_wdata = ^bus.wdata;

  assign gpio_o     = out_r;
  assign gpio_oe    = dir_r;
  assign xclk       = xclk_r;
  assign done       = done_r;
  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;

  // Plain read/write control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= '0;
      dir_r <= '0;
      div_r <= DIV_RST;
    end else if (bus.we) begin
      case (bus.addr)
        A_OUT:   out_r <= wdata_w;
        A_DIR:   dir_r <= wdata_w;
        A_DIV:   div_r <= bus.wdata[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_i;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] status_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] sync_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] status_clr;
  logic [1:0]       warm;
  logic             edge_en;

  // Detection stays off until sync_d holds a real pin sample, so a pin
  // already high at reset release is not seen as a rising edge.
  assign edge_en    = (warm == 2'd3);
  assign edge_set   = edge_en ? (( sync2 & ~sync_d & rise_en_r) |
                                 (~sync2 &  sync_d & fall_en_r)) : '0;
  assign status_clr = (bus.we && (bus.addr == A_STATUS)) ? wdata_w : '0;
  assign irq        = |(status_r & mask_r);

  // Edge-detect history and warm-up counter after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_d <= '0;
      warm   <= 2'd0;
    end else begin
      sync_d <= sync2;
      if (!edge_en) warm <= warm + 2'd1;
    end
  end

  // Interrupt configuration and sticky status (a new event beats a clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_r  <= '0;
      mask_r    <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
    end else begin
      status_r <= (status_r & ~status_clr) | edge_set;
      if (bus.we) begin
        case (bus.addr)
          A_MASK:  mask_r    <= wdata_w;
          A_RISE:  rise_en_r <= wdata_w;
          A_FALL:  fall_en_r <= wdata_w;
          default: ;
        endcase
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read-data mux, sampled before any same-cycle write lands.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      A_OUT:    rd_mux[WIDTH-1:0] = out_r;
      A_DIR:    rd_mux[WIDTH-1:0] = dir_r;
      A_IN:     rd_mux[WIDTH-1:0] = sync2;
`ifdef GPIO_EDGE_IRQ_EN
      A_STATUS: rd_mux[WIDTH-1:0] = status_r;
      A_MASK:   rd_mux[WIDTH-1:0] = mask_r;
      A_RISE:   rd_mux[WIDTH-1:0] = rise_en_r;
      A_FALL:   rd_mux[WIDTH-1:0] = fall_en_r;
`endif
      A_DIV:    rd_mux[DIV_W-1:0] = div_r;
      default:  rd_mux = '0;
    endcase
  end

  // Registered read response; rdata holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= bus.re;
      if (bus.re) rdata_r <= rd_mux;
    end
  end

  // Divider: count 0..DIV, toggle xclk and flag done on wrap; a DIV write
  // restarts the count without toggling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      xclk_r <= 1'b0;
      done_r <= 1'b0;
    end else if (wr_div) begin
      cnt    <= '0;
      done_r <= 1'b0;
    end else if (cnt == div_r) begin
      cnt    <= '0;
      xclk_r <= ~xclk_r;
      done_r <= 1'b1;
    end else begin
      cnt    <= cnt + DIV_W'(1);
      done_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: reset, register access, synchronizer
// latency, divider timing and (build-dependent) edge interrupt behaviour.
module tb_gpio_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_i;
  logic [7:0] gpio_o;
  logic [7:0] gpio_oe;
  logic       xclk;
  logic       done;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_ctrl_if bus ();

  gpio_ctrl #(.WIDTH(8), .DIV_W(26)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .xclk    (xclk),
    .done    (done),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.addr = a;
    bus.re   = 1'b1;
    @(negedge clk);
    bus.re   = 1'b0;
    check($sformatf("rvalid_addr%0d", a), {31'd0, bus.rvalid}, 32'd1);
    d = bus.rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        prev;
    int          n;
    int          dn;

    rst       = 1'b0;
    gpio_i    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_gpio_o",  {24'd0, gpio_o},  32'h0);
    check("rst_gpio_oe", {24'd0, gpio_oe}, 32'h0);
    check("rst_xclk",    {31'd0, xclk},    32'h0);
    check("rst_done",    {31'd0, done},    32'h0);
    check("rst_irq",     {31'd0, irq},     32'h0);
    check("rst_rvalid",  {31'd0, bus.rvalid}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Mid-operation reset with outputs driven, xclk high, and a read in flight.
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'hA5);
    wr(3'd7, 32'd1);
    check("pre_rst_oe", {24'd0, gpio_oe}, 32'hFF);
    n = 0;
    while (xclk !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_xclk_high", {31'd0, xclk}, 32'h1);
    bus.addr = 3'd0;
    bus.re   = 1'b1;
    #2;
    rst      = 1'b0;
    bus.re   = 1'b0;
    @(negedge clk);
    check("midrst_gpio_oe", {24'd0, gpio_oe}, 32'h0);
    check("midrst_gpio_o",  {24'd0, gpio_o},  32'h0);
    check("midrst_xclk",    {31'd0, xclk},    32'h0);
    check("midrst_irq",     {31'd0, irq},     32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_no_rvalid", {31'd0, bus.rvalid}, 32'h0);
    rd(3'd7, d);
    check("div_reset_value", d, 32'd33554431);
    rd(3'd0, d);
    check("out_after_rst", d, 32'h0);

    // Register access; upper write bits are dropped.
    wr(3'd0, 32'hFFFF_FF3C);
    wr(3'd1, 32'h0F);
    check("gpio_o_3c",  {24'd0, gpio_o},  32'h3C);
    check("gpio_oe_0f", {24'd0, gpio_oe}, 32'h0F);
    rd(3'd0, d);
    check("rd_out", d, 32'h3C);
    @(negedge clk);
    check("rvalid_one_cycle", {31'd0, bus.rvalid}, 32'h0);
    rd(3'd1, d);
    check("rd_dir", d, 32'h0F);
    @(negedge clk);
    check("rdata_hold", bus.rdata, 32'h0F);

    // Same-cycle write and read of OUT returns the old value.
    bus.addr  = 3'd0;
    bus.wdata = 32'h55;
    bus.we    = 1'b1;
    bus.re    = 1'b1;
    @(negedge clk);
    bus.we    = 1'b0;
    bus.re    = 1'b0;
    check("rw_same_rdata",  bus.rdata, 32'h3C);
    check("rw_same_gpio_o", {24'd0, gpio_o}, 32'h55);

    // IN is read-only.
    wr(3'd2, 32'hFF);
    rd(3'd2, d);
    check("in_write_ignored", d, 32'h0);

    // Synchronizer latency: pin change visible in IN on the third read.
    gpio_i   = 8'h80;
    bus.addr = 3'd2;
    bus.re   = 1'b1;
    @(negedge clk);
    check("sync_cyc1", bus.rdata, 32'h0);
    @(negedge clk);
    check("sync_cyc2", bus.rdata, 32'h0);
    @(negedge clk);
    check("sync_cyc3", bus.rdata, 32'h80);
    bus.re = 1'b0;
    gpio_i = 8'h00;
    repeat (3) @(negedge clk);

    // Divider DIV=3: xclk half-period 4 cycles, one done per toggle.
    wr(3'd7, 32'd3);
    prev = xclk;
    n = 0;
    while (xclk === prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("div3_toggle_seen", {31'd0, (n < 20)}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      prev = xclk;
      n  = 0;
      dn = 0;
      do begin
        @(negedge clk);
        n++;
        dn += int'(done);
      end while (xclk === prev && n < 20);
      check($sformatf("div3_half_period_%0d", k), n, 32'd4);
      check($sformatf("div3_done_count_%0d", k), dn, 32'd1);
    end

    // DIV=0: the write itself produces no done, then clk/2 with done stuck.
    wr(3'd7, 32'd0);
    check("div_write_no_done", {31'd0, done}, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      prev = xclk;
      check($sformatf("div0_done_%0d", k), {31'd0, done}, 32'h1);
      @(negedge clk);
      check($sformatf("div0_toggle_%0d", k), {31'd0, xclk}, {31'd0, ~prev});
    end
    wr(3'd7, 32'd1000);

`ifdef GPIO_EDGE_IRQ_EN
    wr(3'd5, 32'h01);
    wr(3'd4, 32'h01);
    gpio_i = 8'h01;
    repeat (3) @(negedge clk);
    check("irq_after_rise", {31'd0, irq}, 32'h1);
    rd(3'd3, d);
    check("status_set", d, 32'h01);
    wr(3'd3, 32'h00);
    check("status_w0_keeps", {31'd0, irq}, 32'h1);
    wr(3'd3, 32'h01);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    gpio_i = 8'h00;
    repeat (4) @(negedge clk);
    check("no_fall_event", {31'd0, irq}, 32'h0);
    gpio_i = 8'h01;
    repeat (2) @(negedge clk);
    wr(3'd3, 32'h01);
    check("set_beats_clear_irq", {31'd0, irq}, 32'h1);
    rd(3'd3, d);
    check("set_beats_clear_status", d, 32'h01);
`else
    wr(3'd5, 32'h01);
    wr(3'd4, 32'h01);
    gpio_i = 8'h01;
    repeat (4) @(negedge clk);
    check("irq_tied_low", {31'd0, irq}, 32'h0);
    rd(3'd3, d);
    check("status_reads_zero", d, 32'h0);
    rd(3'd4, d);
    check("mask_reads_zero", d, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: number of GPIO pins, legal range 1..32.
REQ-002 Parameter DIV_W, default 26: width of clock-divider register and counter, legal range 1..32.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 addr  input  3  register select.
REQ-006 wdata  input  32  write data; bits above register width ignored.
REQ-007 we  input  1  write strobe, one cycle per write.
REQ-008 re  input  1  read strobe, one cycle per read.
REQ-009 rdata  output  32  read data, registered.
REQ-010 rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-011 gpio_i  input  WIDTH  asynchronous pin inputs.
REQ-012 gpio_o  output  WIDTH  pin output values.
REQ-013 gpio_oe  output  WIDTH  per-pin output enable (1 = drive).
REQ-014 xclk  output  1  divided clock output.
REQ-015 done  output  1  one-cycle pulse on every xclk toggle.
REQ-016 irq  output  1  level interrupt request.

Function
REQ-017 Register map (addr): 0 OUT rw, 1 DIR rw, 2 IN ro, 3 STATUS rw1c, 4 MASK rw, 5 RISE_EN rw, 6 FALL_EN rw, 7 DIV rw (DIV_W bits); registers 0-6 are WIDTH bits.
REQ-018 gpio_o = OUT, gpio_oe = DIR, combinationally from the registers.
REQ-019 gpio_i passes through a 2-flop synchronizer; IN reads the synchronized value (2-cycle latency pin-to-IN).
REQ-020 Write takes effect on the clock edge where we=1; writes to IN are ignored.
REQ-021 Read: rdata/rvalid valid the cycle after re=1; unused upper bits read 0; rdata holds its last value when rvalid=0.
REQ-022 we and re in the same cycle to the same address: read returns the pre-write value.
REQ-023 Edge detect compares synchronized value against its one-cycle-delayed copy; rising edge on bit n with RISE_EN[n]=1, or falling edge with FALL_EN[n]=1, sets STATUS[n].
REQ-024 Writing 1 to STATUS[n] clears it; writing 0 leaves it unchanged; a set event and a clear in the same cycle leave the bit set.
REQ-025 irq = OR of (STATUS & MASK), combinational from registers.
REQ-026 Divider counter counts 0..DIV; on the cycle it equals DIV it wraps to 0, xclk toggles, and done pulses for that cycle.
REQ-027 DIV=0: xclk toggles every cycle (clk/2) and done is high continuously.
REQ-028 Any write to DIV resets the counter to 0 in the same edge; xclk keeps its current level; no done pulse is generated by the write.
REQ-029 The counter wraps naturally at DIV = 2^DIV_W-1; no overflow state exists.

Reset
REQ-030 While rst=0: OUT, DIR, STATUS, MASK, RISE_EN, FALL_EN, counter, synchronizer flops, rdata = 0; rvalid, xclk, done, irq = 0; gpio_oe = 0 (all pins input).
REQ-031 DIV resets to 2^(DIV_W-1) - 1 (default 26 gives 33554431, ~0.75 Hz-class blink at 50 MHz clk).
REQ-032 Reset asserted mid-operation discards any in-flight read (no rvalid after reset release) and clears pending STATUS bits.
REQ-033 After rst deasserts, the first edge-detect evaluation occurs no earlier than the third clk edge, so reset release never produces a spurious STATUS bit.

Configuration
REQ-034 Macro GPIO_EDGE_IRQ_EN: when defined, edge detection, STATUS, MASK, RISE_EN, FALL_EN and irq are implemented as specified.
REQ-035 When GPIO_EDGE_IRQ_EN is not defined, addresses 3-6 read 0 and ignore writes, irq is tied 0, and no edge-detect flops exist; all other behaviour is unchanged.

Verification
REQ-036 Reset: rst=0 mid-count with DIR=0xFF, OUT=0xA5 -> gpio_oe=0x00, gpio_o=0x00, xclk=0, irq=0, DIV reads 33554431 after release.
REQ-037 Register access: write OUT=0x3C, DIR=0x0F, read both -> rvalid one cycle after re, rdata 0x3C then 0x0F; gpio_o=0x3C, gpio_oe=0x0F.
REQ-038 Divider: write DIV=3 -> xclk toggles every 4 clk cycles (period 8), done pulses once per toggle; write DIV=0 -> xclk period 2, done stuck high.
REQ-039 Edge IRQ (macro on): RISE_EN=0x01, MASK=0x01, drive gpio_i[0] 0->1 -> STATUS=0x01 and irq=1 within 3 cycles; write STATUS=0x01 -> irq=0; clear coinciding with a new edge -> STATUS stays 0x01.
REQ-040 Macro off: same stimulus as REQ-039 -> irq stays 0, address 3 reads 0.
REQ-041 Synchronizer: pulse gpio_i=0x80 -> IN reads 0x80 no earlier than 2 cycles after the pin changes.
